// File: rtl/node_stream_tx.sv
// node_stream_tx: snapshots a frame of NODE_COUNT (x,y) nodes on start and
// streams one node per accepted beat over a valid/ready output port.
//
// Ports:
//   clk, reset          clock; synchronous active-low reset
//   nodes_x, nodes_y    packed node coordinates, node i at [i*COORD_W +: COORD_W]
//   start               one-cycle request to capture and send a frame
//   out_ready           downstream ready
//   out_valid/out_index/out_x/out_y/out_last   current beat
//   busy                high while a frame is being sent or completing
//   frame_done          one-cycle pulse after the last beat is accepted
//   frame_count         completed frames (wrapping)
//   drop_count          start requests ignored while busy (saturating)
module node_stream_tx #(
    parameter int NODE_COUNT = 5,
    parameter int COORD_W    = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NODE_COUNT*COORD_W-1:0] nodes_x,
    input  logic [NODE_COUNT*COORD_W-1:0] nodes_y,
    input  logic                          start,
    input  logic                          out_ready,
    output logic                          out_valid,
    output logic [7:0]                    out_index,
    output logic [COORD_W-1:0]            out_x,
    output logic [COORD_W-1:0]            out_y,
    output logic                          out_last,
    output logic                          busy,
    output logic                          frame_done,
    output logic [15:0]                   frame_count,
    output logic [7:0]                    drop_count
);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DONE
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(NODE_COUNT - 1);

    state_t state;
    state_t state_nxt;

    logic [NODE_COUNT*COORD_W-1:0] snap_x;
    logic [NODE_COUNT*COORD_W-1:0] snap_y;
    logic [7:0]                    idx;
    logic [7:0]                    idx_nxt;
    logic [31:0]                   sel;
    logic                          launch;
    logic                          accept;

    assign out_index = idx;
    assign idx_nxt   = idx + 8'd1;
    assign sel       = 32'(idx_nxt) * 32'(COORD_W);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        busy       = 1'b0;
        frame_done = 1'b0;
        launch     = 1'b0;
        accept     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    launch    = 1'b1;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_last  = (idx == LAST_IDX);
                accept    = out_ready;
                if (accept && out_last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                frame_done = 1'b1;
                state_nxt  = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Node 0 is presented straight from the inputs on the capture edge so
    // the first beat is valid immediately; later nodes come from the snapshot.
    always_ff @(posedge clk) begin
        if (!reset) begin
            snap_x      <= '0;
            snap_y      <= '0;
            idx         <= '0;
            out_x       <= '0;
            out_y       <= '0;
            frame_count <= '0;
            drop_count  <= '0;
        end else begin
            if (launch) begin
                snap_x <= nodes_x;
                snap_y <= nodes_y;
                idx    <= '0;
                out_x  <= nodes_x[COORD_W-1:0];
                out_y  <= nodes_y[COORD_W-1:0];
            end else if (accept && !out_last) begin
                idx   <= idx_nxt;
                out_x <= snap_x[sel +: COORD_W];
                out_y <= snap_y[sel +: COORD_W];
            end
            if (accept && out_last) begin
                frame_count <= frame_count + 16'd1;
            end
            if (start && state != IDLE && drop_count != 8'hFF) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end

endmodule

// File: doc/node_stream_tx.md
NODE_STREAM_TX -- requirements
Module: node_stream_tx

Interface
REQ-001 Parameter NODE_COUNT, default 5: number of nodes per frame; legal range 1..255.
REQ-002 Parameter COORD_W, default 32: width of one coordinate.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; reset asserted when low, sampled on the rising edge of clk.
REQ-005 nodes_x  input  NODE_COUNT*COORD_W  packed x positions; node i in bits [(i+1)*COORD_W-1 : i*COORD_W].
REQ-006 nodes_y  input  NODE_COUNT*COORD_W  packed y positions; same packing as nodes_x.
REQ-007 start  input  1  one-cycle request to snapshot and transmit one frame.
REQ-008 out_ready  input  1  downstream ready.
REQ-009 out_valid  output  1  current beat valid.
REQ-010 out_index  output  8  node index of the current beat.
REQ-011 out_x  output  COORD_W  x of the current node.
REQ-012 out_y  output  COORD_W  y of the current node.
REQ-013 out_last  output  1  current beat is node NODE_COUNT-1.
REQ-014 busy  output  1  high in SEND and DONE.
REQ-015 frame_done  output  1  one-cycle pulse after the last beat is accepted.
REQ-016 frame_count  output  16  count of completed frames; wraps 0xFFFF->0.
REQ-017 drop_count  output  8  count of ignored start requests; saturates at 0xFF.

Function
REQ-018 FSM states SHALL be IDLE, SEND and DONE.
REQ-019 IDLE with start=1: the block SHALL copy all nodes_x/nodes_y into an internal snapshot, set index=0 and move to SEND on the same edge.
REQ-020 Latency: start sampled on edge N SHALL give out_valid=1 with node 0 data from edge N until the first beat is accepted.
REQ-021 In SEND, out_x/out_y SHALL come only from the snapshot; input changes after capture SHALL NOT affect the frame.
REQ-022 In SEND, out_valid SHALL be 1; out_index, out_x, out_y and out_last SHALL stay stable while out_ready=0.
REQ-023 A beat SHALL be accepted on an edge where out_valid=1 and out_ready=1; after acceptance index SHALL increment by 1.
REQ-024 out_last SHALL be 1 exactly when out_valid=1 and index=NODE_COUNT-1; with NODE_COUNT=1 the only beat is also the last beat.
REQ-025 When the last beat is accepted, the FSM SHALL move to DONE; in DONE, out_valid SHALL be 0 and frame_done SHALL be 1 for exactly one cycle; frame_count SHALL increment on entry to DONE.
REQ-026 DONE SHALL move to IDLE unconditionally on the next edge.
REQ-027 start=1 in SEND or DONE SHALL be ignored and drop_count SHALL increment, saturating at 0xFF; the frame in progress SHALL be unaffected.
REQ-028 start=1 in the same cycle as DONE->IDLE SHALL count as a drop; a new frame SHALL need start in IDLE.
REQ-029 In IDLE, out_valid, out_last and frame_done SHALL be 0; out_x/out_y/out_index SHALL hold their last values.
REQ-030 Back-to-back frames: minimum start-to-start spacing SHALL be NODE_COUNT+2 cycles with out_ready held at 1.

Reset
REQ-031 reset=0 on an edge SHALL force IDLE and zero index, snapshot, out_index, out_x, out_y, frame_count and drop_count, regardless of state.
REQ-032 Reset mid-frame SHALL abandon the frame with no frame_done and no frame_count change; out_valid SHALL be 0 on the next cycle.
REQ-033 start SHALL be ignored while reset=0 and SHALL NOT be counted as a drop.

Verification
REQ-034 NODE_COUNT=5, x_i=0x100+i, y_i=0x200+i, out_ready=1, start pulse -> 5 beats on consecutive cycles, index 0..4, out_last only on index 4, frame_done one cycle later, frame_count=1.
REQ-035 Change nodes_x to all 0xFFFFFFFF one cycle after start -> transmitted x values stay 0x100..0x104.
REQ-036 out_ready toggles 1,0,0,1,... -> no beat lost or duplicated; data stable during stalls; indices in order.
REQ-037 Three start pulses during SEND -> drop_count=3, frame unaffected; 300 extra pulses -> drop_count=0xFF.
REQ-038 reset=0 after beat 2 accepted -> next cycle out_valid=0, FSM in IDLE, no frame_done, counters 0.
REQ-039 NODE_COUNT=1, start with out_ready=0 for 3 cycles then 1 -> single beat with out_last=1 and index 0, then frame_done.
